// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared CPU constants and the fetch-unit state enumeration
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] CPU_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
// fetch_skid : one-entry holding register for a word returned while stalled
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capture,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc4;

  // Clear wins over capture so a flush never leaves a stale word behind.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_capture) begin
      r_inst <= i_inst;
      r_pc4  <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-outstanding instruction fetch with stall skid and redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc4,
  output logic        out_valid
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc4;

  logic        w_req;
  logic        w_capture;
  logic        w_clear;
  logic [31:0] w_pc4;
  logic [31:0] w_redirect_pc;

  logic        w_skid_valid;
  logic [31:0] w_skid_inst;
  logic [31:0] w_skid_pc4;

  assign w_req         = !rst && !stall && !redirect;
  assign w_pc4         = pc_plus4(r_pc);
  assign w_redirect_pc = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    if (redirect) begin
      w_state_nxt = ST_START;
      w_clear     = 1'b1;
    end else if (w_req) begin
      w_state_nxt = ST_RUN;
      w_clear     = w_skid_valid;
    end else begin
      // Stalled: park the returning word; START and HOLD simply wait.
      case (r_state)
        ST_RUN: begin
          if (r_inflight) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_inflight     <= 1'b0;
      r_inflight_pc4 <= RESET_PC;
    end else if (redirect) begin
      r_pc       <= w_redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_req) begin
      r_pc           <= w_pc4;
      r_inflight     <= 1'b1;
      r_inflight_pc4 <= w_pc4;
    end else if (w_capture) begin
      r_inflight <= 1'b0;
    end
  end

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_clear   (w_clear),
    .i_inst    (imem_rdata),
    .i_pc4     (r_inflight_pc4),
    .o_valid   (w_skid_valid),
    .o_inst    (w_skid_inst),
    .o_pc4     (w_skid_pc4)
  );

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  // Depends only on registered state and imem_rdata, never on stall/redirect.
  always_comb begin
    out_inst  = NOP_INST;
    out_pc4   = r_pc;
    out_valid = 1'b0;
    if (w_skid_valid) begin
      out_inst  = w_skid_inst;
      out_pc4   = w_skid_pc4;
      out_valid = 1'b1;
    end else if (r_inflight) begin
      out_inst  = imem_rdata;
      out_pc4   = r_inflight_pc4;
      out_valid = 1'b1;
    end
  end

endmodule

`default_nettype wire
